bcd_dabble_seq: RTL and testbench
=================================

Name: bcd_dabble_seq

Overview:
Multi-cycle shift-add-3 (double-dabble) binary-to-BCD converter with a start/done handshake. It sits between the 8-bit counter and the seven-segment display driver. It converts the latched count into packed BCD digits plus a leading-zero blank mask, and it holds the result stable between conversions so the display never shows intermediate digits.

Parameters:
WIDTH, 8, binary input width in bits (>= 1)
DIGITS, 3, number of BCD output digits; elaboration must fail if 10^DIGITS - 1 < 2^WIDTH - 1
CNT_W, $clog2(WIDTH+1), derived local constant; width of the shift counter

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  conversion request; sampled only when ready=1
bin  input  WIDTH  binary value; sampled on the accepting edge only
ready  output  1  high in IDLE; a start is accepted this cycle
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when bcd/blank are updated
bcd  output  4*DIGITS  packed result: digit i at [4i+3:4i], i=0 is ones
blank  output  DIGITS  bit i high means digit i is a leading zero

Behaviour:
- Reset (async assert, sync-style release): state=IDLE, ready=1, busy=0, done=0, bcd=0, blank = all ones except bit0=0, shift counter=0, internal shift register=0.
- FSM states:
  - IDLE: if start=1 at edge k, load bin into shift register, clear the BCD accumulator, counter=0, go to SHIFT. Otherwise stay in IDLE.
  - SHIFT: on each edge, for every accumulator digit >= 5 add 3 (4-bit, no carry between digits). Then shift {accumulator, shift register} left by 1 and increment the counter. After WIDTH shifts (edge k+WIDTH), go to IDLE.
- On edge k+WIDTH, bcd and blank load from the final accumulator. done=1 for exactly the cycle after that edge.
- Latency: start sampled at edge k gives the result visible and done=1 after edge k+WIDTH (8 cycles at default). busy=1 from after edge k through edge k+WIDTH. ready = ~busy.
- A start while busy=1 is ignored: no queueing and no effect on the conversion in flight.
- Back-to-back: start=1 during the done cycle (ready=1) is accepted. bcd holds the previous result until the next completion.
- bin changing during SHIFT has no effect; only the value sampled at edge k is used.
- blank rule: bit i=1 iff digits DIGITS-1..i are all zero and i>0. Digit 0 is never blanked, so 0 displays as a single "0".
- Reset asserted mid-conversion: abort immediately, outputs return to reset values, no done pulse. After release, the block is ready on the first edge.
- bcd/blank are registered outputs with no combinational path from bin or start. done is registered.
- Max value 2^WIDTH-1 must convert exactly. Digit values are always 0..9.

Decomposition:
- Shared package (display_pkg): BCD_DIGIT_W=4, DEF_DIGITS=3, the FSM state enum {IDLE, SHIFT}, and a function computing the minimum digits for a given WIDTH (used in the elaboration check).
- One natural sub-module: bcd_add3_digit, a combinational 4-bit "if >=5 then +3" cell instantiated DIGITS times per shift step.
- No further hierarchy.

Test Plan:
- Reset then start with bin=255: done at cycle 8 after accept; bcd=0x255, blank=000; busy high for exactly 8 cycles.
- bin=0: bcd=0x000, blank=110. bin=7: bcd=0x007, blank=110. bin=42: bcd=0x042, blank=100.
- Start with bin=100, then pulse start with bin=9 at cycles 3 and 5 of the conversion: result is 0x100, only one done pulse, and bcd is unchanged until then.
- Start on the done cycle of a 255 conversion with bin=128: accepted; bcd=0x255 holds for 8 cycles, then becomes 0x128 with a second done pulse.
- Assert rst_n=0 at cycle 4 of a bin=200 conversion: bcd=0, busy=0, and done never pulses. After release, start with bin=200 gives 0x200.
- Exhaustive sweep of bin=0..255 against a reference model: every bcd/blank matches, and latency is always 8 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the display path (counter -> BCD -> seven-segment).
//   BCD_DIGIT_W : bits per packed BCD digit
//   DEF_DIGITS  : default number of BCD digits
//   state_e     : converter FSM states
//   min_digits  : decimal digits needed to hold 2^width - 1
package display_pkg;

  localparam int unsigned BCD_DIGIT_W = 4;
  localparam int unsigned DEF_DIGITS  = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  // 2^w is never a power of ten for w >= 1, so the digit count of 2^w - 1 is
  // floor(w * log10(2)) + 1. log10(2) is approximated as 0.30103.
  function automatic int unsigned min_digits(input int unsigned width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_dabble_seq_if.sv
// Start/done handshake and result bus of the binary-to-BCD converter.
//   start, bin              : request and binary operand (driven by master)
//   ready, busy, done       : handshake status (driven by slave)
//   bcd, blank              : packed BCD digits and leading-zero mask (driven by slave)
interface bcd_dabble_seq_if #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
);

  logic                start;
  logic [WIDTH-1:0]    bin;
  logic                ready;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;
  logic [DIGITS-1:0]   blank;

  modport master (
    output start, bin,
    input  ready, busy, done, bcd, blank
  );

  modport slave (
    input  start, bin,
    output ready, busy, done, bcd, blank
  );

endinterface

// File: rtl/bcd_add3_digit.sv
// Double-dabble correction cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
//   digit_i : 4-bit BCD digit before correction
//   digit_o : corrected 4-bit digit (no carry out)
module bcd_add3_digit (
  input  logic [3:0] digit_i,
  output logic [3:0] digit_o
);

  always_comb begin
    digit_o = (digit_i >= 4'd5) ? digit_i + 4'd3 : digit_i;
  end

endmodule

// File: rtl/bcd_dabble_seq.sv
// Multi-cycle shift-add-3 binary-to-BCD converter.
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of bcd_dabble_seq_if
//           start/bin accepted while ready; done pulses one cycle when bcd/blank
//           update; bcd/blank hold the last result between conversions.
module bcd_dabble_seq
  import display_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = DEF_DIGITS
) (
  input  logic            clk,
  input  logic            rst_n,
  bcd_dabble_seq_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned BCD_W = BCD_DIGIT_W * DIGITS;
  // Digit 0 is never blanked, so an all-zero display still shows "0".
  localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1'b1);

  if (DIGITS < min_digits(WIDTH)) begin : gen_digits_check
    $error("bcd_dabble_seq: DIGITS too small for WIDTH");
  end

  state_e            state_q;
  logic [WIDTH-1:0]  sr_q;
  logic [BCD_W-1:0]  acc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BCD_W-1:0]  bcd_q;
  logic [DIGITS-1:0] blank_q;
  logic              done_q;

  logic [BCD_W-1:0]  acc_adj;
  logic [BCD_W-1:0]  acc_d;
  logic [WIDTH-1:0]  sr_d;
  logic [DIGITS-1:0] blank_d;
  logic              upper_zero;
  logic              last_shift;
  logic              unused_acc_msb;

  for (genvar g = 0; g < DIGITS; g++) begin : gen_add3
    bcd_add3_digit u_add3 (
      .digit_i (acc_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
      .digit_o (acc_adj[g*BCD_DIGIT_W +: BCD_DIGIT_W])
    );
  end

  // Shift {accumulator, shift register} left by one after correction.
  assign acc_d          = {acc_adj[BCD_W-2:0], sr_q[WIDTH-1]};
  assign sr_d           = sr_q << 1;
  assign unused_acc_msb = acc_adj[BCD_W-1];
  assign last_shift     = (cnt_q == CNT_W'(WIDTH - 1));

  // Digit i is blank when it and every digit above it are zero (i > 0).
  always_comb begin
    blank_d    = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (acc_d[i*BCD_DIGIT_W +: BCD_DIGIT_W] == 4'd0);
      blank_d[i] = upper_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sr_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      bcd_q   <= '0;
      blank_q <= BLANK_RST;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            sr_q    <= bus.bin;
            acc_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          acc_q <= acc_d;
          sr_q  <= sr_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last_shift) begin
            state_q <= IDLE;
            bcd_q   <= acc_d;
            blank_q <= blank_d;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy  = (state_q == SHIFT);
  assign bus.ready = (state_q == IDLE);
  assign bus.done  = done_q;
  assign bus.bcd   = bcd_q;
  assign bus.blank = blank_q;

endmodule

// File: tb/tb_bcd_dabble_seq.sv
// Scoreboard bench for bcd_dabble_seq: the driver pushes the expected result on
// every accepted start; a negedge monitor pops and compares on each done pulse,
// and checks latency, busy width and that bcd holds between completions.
module tb_bcd_dabble_seq;

  localparam int unsigned W = 8;
  localparam int unsigned D = 3;

  typedef struct {
    logic [11:0] bcd;
    logic [2:0]  blank;
    int unsigned acc_cyc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int unsigned checks;
  int unsigned errors;
  exp_t        sb_q[$];
  exp_t        e;
  logic [11:0] last_bcd;
  int unsigned busy_run;

  bcd_dabble_seq_if #(.WIDTH(W), .DIGITS(D)) bus ();

  bcd_dabble_seq #(.WIDTH(W), .DIGITS(D)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [11:0] ref_bcd(input int v);
    ref_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [2:0] ref_blank(input logic [11:0] b);
    ref_blank = {b[11:8] == 4'd0, (b[11:8] == 4'd0) && (b[7:4] == 4'd0), 1'b0};
  endfunction

  // Call at a negedge. Waits (bounded) for ready, then issues one start.
  task automatic send(input logic [7:0] b, input logic [11:0] xb, input logic [2:0] xk);
    exp_t x;
    int   t;
    t = 0;
    while (!bus.ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!bus.ready) check("ready_timeout", 32'd0, 32'd1);
    bus.start = 1'b1;
    bus.bin   = b;
    x.bcd     = xb;
    x.blank   = xk;
    x.acc_cyc = cyc + 1;
    sb_q.push_back(x);
    @(negedge clk);
    bus.start = 1'b0;
    bus.bin   = 8'($urandom);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      last_bcd = 12'h000;
      busy_run = 0;
      check("done_in_reset", 32'(bus.done), 32'd0);
    end else begin
      if (bus.done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          check("bcd", 32'(bus.bcd), 32'(e.bcd));
          check("blank", 32'(bus.blank), 32'(e.blank));
          check("latency", cyc - e.acc_cyc, W);
          check("busy_width", busy_run, W);
        end
        last_bcd = bus.bcd;
      end else begin
        check("bcd_hold", 32'(bus.bcd), 32'(last_bcd));
      end
      busy_run = bus.busy ? busy_run + 1 : 0;
    end
  end

  initial begin
    int t;
    checks    = 0;
    errors    = 0;
    last_bcd  = 12'h000;
    busy_run  = 0;
    rst_n     = 1'b0;
    bus.start = 1'b0;
    bus.bin   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    check("rst_ready", 32'(bus.ready), 32'd1);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_bcd", 32'(bus.bcd), 32'h000);
    check("rst_blank", 32'(bus.blank), 32'b110);

    send(8'd255, 12'h255, 3'b000);
    send(8'd0,   12'h000, 3'b110);
    send(8'd7,   12'h007, 3'b110);
    send(8'd42,  12'h042, 3'b100);

    // Starts at cycles 3 and 5 of a conversion must be ignored.
    send(8'd100, 12'h100, 3'b000);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 8'd9;
    @(negedge clk);
    bus.start = 1'b0;

    // 128 is issued on the done cycle of the 255 conversion.
    send(8'd255, 12'h255, 3'b000);
    send(8'd128, 12'h128, 3'b000);

    // Abort a conversion with reset partway through.
    send(8'd200, 12'h200, 3'b000);
    repeat (3) @(negedge clk);
    #2;
    rst_n = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check("abort_bcd", 32'(bus.bcd), 32'h000);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_ready", 32'(bus.ready), 32'd1);
    check("abort_blank", 32'(bus.blank), 32'b110);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    send(8'd200, 12'h200, 3'b000);

    for (int v = 0; v < 256; v++) begin
      send(8'(v), ref_bcd(v), ref_blank(ref_bcd(v)));
    end

    t = 0;
    while ((sb_q.size() != 0 || bus.busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    check("scoreboard_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
